div_unit: RTL and testbench

Multi-cycle iterative divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the combinational ALU in the EX stage. The ALU covers single-cycle arithmetic; this block takes the division group off that critical path and answers the EX stage over a start/done handshake. While an operation is in flight it raises `stall` so the hazard unit freezes IF/ID/EX.

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_unit_step.sv | 26 ++
 rtl/div_unit.sv | 139 +++++++++++++
 tb/tb_div_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider: op codes, FSM states, op decode helpers.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivOp_div  = 2'd0,
    DivOp_divu = 2'd1,
    DivOp_rem  = 2'd2,
    DivOp_remu = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } div_state_e;

  function automatic logic op_signed(input logic [1:0] op);
    return (op == DivOp_div) || (op == DivOp_rem);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DivOp_rem) || (op == DivOp_remu);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step: shift {rem,quo} left, compare, conditional subtract.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = (rem_in << 1) | {{WIDTH{1'b0}}, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    rem_out = shifted;
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_out    = diff;
      quo_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with start/done handshake and stall.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state, state_nx;

  logic [1:0]       op_q;
  logic             sign_q, sign_r, dz_q, ovf_q;
  logic [WIDTH-1:0] divisor, quo, step_quo;
  logic [WIDTH:0]   rem, step_rem;
  logic [CW-1:0]    count;

  logic             is_signed, start_zero, start_ovf, early_out;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix, fix_result;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem),
    .quo_in (quo),
    .divisor(divisor),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  always_comb begin
    is_signed  = op_signed(op);
    a_abs      = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs      = (is_signed && b[WIDTH-1]) ? -b : b;
    start_zero = (b == '0);
    start_ovf  = is_signed && (a == MIN_NEG) && (b == '1);
  end

`ifdef DIV_EARLY_OUT_EN
  logic [WIDTH-1:0] early_result;
  assign early_out = start_zero | start_ovf;
  always_comb begin
    if (start_zero) early_result = op_is_rem(op) ? a : '1;
    else            early_result = op_is_rem(op) ? '0 : MIN_NEG;
  end
`else
  assign early_out = 1'b0;
`endif

  // Corrected remainder of x/0 already equals the original dividend, so only quotients are forced.
  always_comb begin
    q_fix = (op_signed(op_q) && sign_q) ? -quo : quo;
    r_fix = (op_signed(op_q) && sign_r) ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (dz_q) q_fix = '1;
    if (ovf_q) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
    fix_result = op_is_rem(op_q) ? r_fix : q_fix;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = early_out ? S_DONE : S_RUN;
        else       state_nx = S_IDLE;
      end
      S_RUN:   if (count == CW'(1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  assign stall = busy | (start & ((state == S_IDLE) | (state == S_DONE)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      count   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_RUN) || (state_nx == S_FIX);
      done  <= (state_nx == S_DONE);
      if (!flush) begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              op_q    <= op;
              sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r  <= a[WIDTH-1];
              dz_q    <= start_zero;
              ovf_q   <= start_ovf;
              divisor <= b_abs;
              quo     <= a_abs;
              rem     <= '0;
              count   <= CW'(WIDTH);
`ifdef DIV_EARLY_OUT_EN
              if (early_out) result <= early_result;
`endif
            end
          end
          S_RUN: begin
            rem   <= step_rem;
            quo   <= step_quo;
            count <= count - 1'b1;
          end
          S_FIX:   result <= fix_result;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, flush, back-to-back, reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  localparam int LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int   SP_LAT  = 1;
  localparam logic SP_BUSY = 1'b0;
`else
  localparam int   SP_LAT  = 34;
  localparam logic SP_BUSY = 1'b1;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic        bsy;
  } vec_t;

  vec_t arith [10] = '{
    '{DivOp_div,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT, 1'b1},
    '{DivOp_rem,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT, 1'b1},
    '{DivOp_div,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT, 1'b1},
    '{DivOp_rem,  32'd7,        32'hFFFFFFFE, 32'h00000001, LAT, 1'b1},
    '{DivOp_div,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, LAT, 1'b1},
    '{DivOp_rem,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, LAT, 1'b1},
    '{DivOp_divu, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, LAT, 1'b1},
    '{DivOp_remu, 32'hFFFFFFFF, 32'd16,       32'h0000000F, LAT, 1'b1},
    '{DivOp_divu, 32'd100,      32'd7,        32'd14,       LAT, 1'b1},
    '{DivOp_remu, 32'd100,      32'd7,        32'd2,        LAT, 1'b1}
  };

  vec_t special [10] = '{
    '{DivOp_div,  32'd5,        32'd0,        32'hFFFFFFFF, SP_LAT, SP_BUSY},
    '{DivOp_rem,  32'd5,        32'd0,        32'd5,        SP_LAT, SP_BUSY},
    '{DivOp_divu, 32'd5,        32'd0,        32'hFFFFFFFF, SP_LAT, SP_BUSY},
    '{DivOp_remu, 32'd5,        32'd0,        32'd5,        SP_LAT, SP_BUSY},
    '{DivOp_div,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SP_LAT, SP_BUSY},
    '{DivOp_rem,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SP_LAT, SP_BUSY},
    '{DivOp_div,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, SP_LAT, SP_BUSY},
    '{DivOp_rem,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, SP_LAT, SP_BUSY},
    '{DivOp_divu, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT,    1'b1},
    '{DivOp_remu, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT,    1'b1}
  };

  div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .result(result),
    .stall (stall)
  );

  always #5 clk = ~clk;

  // Drives start for exactly one cycle N; returns at cycle N+1, 1 time unit after the edge.
  task automatic pulse_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at cycle N+1; lat is the offset from N of the first done cycle, -1 on timeout.
  task automatic wait_done(output int lat, output logic [31:0] res, output logic busy_seen);
    lat = -1; res = '0; busy_seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_seen = 1'b1;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", result); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall_idle: got %b expected 0", stall); end
    start = 1'b1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL reset_stall_start: got %b expected 1", stall); end
    start = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t v [10]);
    int lat; logic [31:0] res; logic bs;
    for (int i = 0; i < 10; i++) begin
      pulse_start(v[i].op, v[i].a, v[i].b);
      wait_done(lat, res, bs);
      tests++; if (res !== v[i].exp) begin fails++; $display("FAIL %s[%0d]_result: got %h expected %h", name, i, res, v[i].exp); end
      tests++; if (lat != v[i].lat) begin fails++; $display("FAIL %s[%0d]_latency: got %0d expected %0d", name, i, lat, v[i].lat); end
      tests++; if (bs !== v[i].bsy) begin fails++; $display("FAIL %s[%0d]_busy_seen: got %b expected %b", name, i, bs, v[i].bsy); end
      tests++; if ({busy, stall} !== 2'b00) begin fails++; $display("FAIL %s[%0d]_done_cycle_busy_stall: got %b expected 00", name, i, {busy, stall}); end
      @(posedge clk); #1;
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s[%0d]_done_pulse_width: got %b expected 0", name, i, done); end
    end
  endtask

  task automatic test_arith();
    run_table("arith", arith);
  endtask

  task automatic test_special();
    run_table("special", special);
  endtask

  task automatic test_flush();
    int lat; int ndone; logic [31:0] res; logic bs;
    pulse_start(DivOp_divu, 32'd100, 32'd7);
    wait_done(lat, res, bs);
    tests++; if (res !== 32'd14) begin fails++; $display("FAIL flush_setup_result: got %h expected %h", res, 32'd14); end
    pulse_start(DivOp_divu, 32'd1000, 32'd3);
    ndone = 0;
    repeat (9) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if ({busy, done, stall} !== 3'b000) begin fails++; $display("FAIL flush_n11_busy_done_stall: got %b expected 000", {busy, done, stall}); end
    repeat (40) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    tests++; if (ndone != 0) begin fails++; $display("FAIL flush_no_done: got %0d pulses expected 0", ndone); end
    tests++; if (result !== 32'd14) begin fails++; $display("FAIL flush_result_held: got %h expected %h", result, 32'd14); end
    pulse_start(DivOp_divu, 32'd1000, 32'd3);
    wait_done(lat, res, bs);
    tests++; if (res !== 32'd333) begin fails++; $display("FAIL flush_restart_result: got %h expected %h", res, 32'd333); end
    tests++; if (lat != LAT) begin fails++; $display("FAIL flush_restart_latency: got %0d expected %0d", lat, LAT); end
    // start and flush in the same IDLE cycle: the start must be dropped
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = DivOp_divu; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_drop_start_busy: got %b expected 0", busy); end
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    tests++; if (ndone != 0) begin fails++; $display("FAIL flush_drop_start_done: got %0d pulses expected 0", ndone); end
    tests++; if (result !== 32'd333) begin fails++; $display("FAIL flush_drop_start_result: got %h expected %h", result, 32'd333); end
  endtask

  task automatic test_back_to_back();
    int lat; int ndone; int first; logic [31:0] res; logic [31:0] fres; logic bs;
    pulse_start(DivOp_divu, 32'd100, 32'd7);
    wait_done(lat, res, bs);
    tests++; if (res !== 32'd14) begin fails++; $display("FAIL b2b_first_result: got %h expected %h", res, 32'd14); end
    start = 1'b1; op = DivOp_divu; a = 32'd1000; b = 32'd3;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL b2b_stall_in_done: got %b expected 1", stall); end
    @(posedge clk); #1;
    start = 1'b0;
    tests++; if ({done, busy} !== 2'b01) begin fails++; $display("FAIL b2b_accept_done_busy: got %b expected 01", {done, busy}); end
    wait_done(lat, res, bs);
    tests++; if (res !== 32'd333) begin fails++; $display("FAIL b2b_second_result: got %h expected %h", res, 32'd333); end
    tests++; if (lat != LAT) begin fails++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT); end
    // start pulses while running must not restart or add completions
    pulse_start(DivOp_divu, 32'd100, 32'd7);
    ndone = 0; first = -1; fres = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5 || k == 20) begin
        start = 1'b1; op = DivOp_divu; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first < 0) begin first = k; fres = result; end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    tests++; if (ndone != 1) begin fails++; $display("FAIL run_start_ignored_count: got %0d pulses expected 1", ndone); end
    tests++; if (first != LAT) begin fails++; $display("FAIL run_start_ignored_latency: got %0d expected %0d", first, LAT); end
    tests++; if (fres !== 32'd14) begin fails++; $display("FAIL run_start_ignored_result: got %h expected %h", fres, 32'd14); end
  endtask

  task automatic test_rst_mid();
    int ndone;
    pulse_start(DivOp_divu, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if ({busy, done, stall} !== 3'b000) begin fails++; $display("FAIL rst_mid_busy_done_stall: got %b expected 000", {busy, done, stall}); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL rst_mid_result: got %h expected 0", result); end
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    tests++; if (ndone != 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
